// File: rtl/ft245_pkg.sv
// ft245_pkg
// Shared types and constants for the FT245 asynchronous FIFO responder.
//   rdState_t / wrState_t : read-side and write-side strobe FSM states
//   DEF_*                 : default strobe timing in system clock cycles
//   cntWidth()            : delay counter width, $clog2(largest delay)+1
package ft245_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_DLY,
        R_DRIVE,
        R_PRE
    } rdState_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_PRE,
        W_WAIT
    } wrState_t;

    localparam int DEF_RD_DATA_DLY = 2;
    localparam int DEF_RXF_PRECHG  = 3;
    localparam int DEF_TXE_PRECHG  = 3;

    // One extra bit of headroom so a loaded value of exactly the largest
    // delay still fits when that delay is a power of two.
    function automatic int cntWidth(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_8bit.sv
// fifo_sync_8bit
// Single-clock byte FIFO with first-word-fall-through output.
//   clock, reset   : clock and asynchronous active-high reset
//   writeEnable    : push writeData (ignored while full)
//   readEnable     : pop the head (ignored while empty)
//   readData       : current head byte, valid whenever empty is low
//   full, empty    : occupancy flags
module fifo_sync_8bit #(
    parameter int pDepth = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       writeEnable,
    input  logic [7:0] writeData,
    input  logic       readEnable,
    output logic [7:0] readData,
    output logic       full,
    output logic       empty
);

    localparam int addrW = $clog2(pDepth);
    localparam logic [addrW:0] ptrOne = (addrW + 1)'(1);

    logic [7:0]     mem [pDepth];
    logic [addrW:0] wrPtr;
    logic [addrW:0] rdPtr;
    logic           doWrite;
    logic           doRead;

    // Pointers carry one bit beyond the address so that full and empty
    // stay distinguishable when the addresses wrap onto each other.
    assign doWrite  = writeEnable && !full;
    assign doRead   = readEnable && !empty;
    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[addrW] != rdPtr[addrW]) &&
                      (wrPtr[addrW-1:0] == rdPtr[addrW-1:0]);
    assign readData = mem[rdPtr[addrW-1:0]];

    // Pointer registers; reset empties the buffer without touching storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + ptrOne;
            if (doRead)  rdPtr <= rdPtr + ptrOne;
        end
    end

    // Storage array, written only for accepted pushes.
    always_ff @(posedge clock) begin
        if (doWrite) mem[wrPtr[addrW-1:0]] <= writeData;
    end

endmodule

// File: rtl/ft245_pin_sync.sv
// ft245_pin_sync
// Two-flop synchronizers for the asynchronous FT245 pins plus edge detect.
//   iClk, iRst_n     : system clock, asynchronous active-low reset
//   iRd_n, iWr_n     : raw RD# / WR# strobes from the master
//   iData            : raw data bus
//   rdSync, wrSync   : synchronized strobes
//   rdFall, rdRise   : one-cycle RD# edge pulses (synced domain)
//   wrFall           : one-cycle WR# falling-edge pulse
//   dataSync         : data bus from the same synchronizer depth as WR#
module ft245_pin_sync (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iRd_n,
    input  logic       iWr_n,
    input  logic [7:0] iData,
    output logic       rdSync,
    output logic       wrSync,
    output logic       rdFall,
    output logic       rdRise,
    output logic       wrFall,
    output logic [7:0] dataSync
);

    logic [1:0] rdStage;
    logic [1:0] wrStage;
    logic [7:0] dataMeta;
    logic [7:0] dataStage;
    logic       rdPrev;
    logic       wrPrev;

    // Strobes reset to their idle-high level so release of reset never
    // looks like a falling edge.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rdStage   <= 2'b11;
            wrStage   <= 2'b11;
            rdPrev    <= 1'b1;
            wrPrev    <= 1'b1;
            dataMeta  <= '0;
            dataStage <= '0;
        end else begin
            rdStage   <= {rdStage[0], iRd_n};
            wrStage   <= {wrStage[0], iWr_n};
            rdPrev    <= rdStage[1];
            wrPrev    <= wrStage[1];
            dataMeta  <= iData;
            dataStage <= dataMeta;
        end
    end

    assign rdSync   = rdStage[1];
    assign wrSync   = wrStage[1];
    assign rdFall   = rdPrev && !rdStage[1];
    assign rdRise   = !rdPrev && rdStage[1];
    assign wrFall   = wrPrev && !wrStage[1];
    assign dataSync = dataStage;

endmodule

// File: rtl/ft245_async_responder.sv
// ft245_async_responder
// Device-side model of the FT2232H asynchronous 245-FIFO interface.
//   Host side : iHostTx* pushes bytes toward the FPGA master (read over RD#),
//               oHostRx* delivers bytes the master wrote over WR# (FWFT).
//   Pin side  : ioFifoData bus, iRd_n / iWr_n strobes, oRxF_n / oTxE_n flags.
//   Errors    : sticky oRdErr / oWrErr / oBusErr, cleared by iErrClr.
module ft245_async_responder
    import ft245_pkg::*;
#(
    parameter int pHostRxDepth = 8,
    parameter int pHostTxDepth = 8,
    parameter int pRdDataDly   = DEF_RD_DATA_DLY,
    parameter int pRxfPrechg   = DEF_RXF_PRECHG,
    parameter int pTxePrechg   = DEF_TXE_PRECHG
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iHostTxValid,
    input  logic [7:0] iHostTxData,
    output logic       oHostTxReady,
    output logic       oHostRxValid,
    output logic [7:0] oHostRxData,
    input  logic       iHostRxReady,
    inout  wire  [7:0] ioFifoData,
    input  logic       iRd_n,
    input  logic       iWr_n,
    output logic       oRxF_n,
    output logic       oTxE_n,
    input  logic       iErrClr,
    output logic       oRdErr,
    output logic       oWrErr,
    output logic       oBusErr
);

    localparam int cntW = cntWidth(pRdDataDly, pRxfPrechg, pTxePrechg);
    localparam logic [cntW-1:0] cntOne = cntW'(1);

    logic rdSync, wrSync, rdFall, rdRise, wrFall;
    logic [7:0] dataSync;
    logic busCond;

    logic h2fPush, h2fPop, h2fFull, h2fEmpty;
    logic [7:0] h2fHead;
    logic f2hPush, f2hPop, f2hFull, f2hEmpty;

    rdState_t rdState, rdStateNext;
    wrState_t wrState, wrStateNext;
    logic [cntW-1:0] rdCnt, rdCntNext, wrCnt, wrCntNext;
    logic rxfReg, txeReg, hostReadyEn, busDrive;
    logic rdErrSet, wrErrSet, busErrSet;

    ft245_pin_sync uPinSync (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iRd_n    (iRd_n),
        .iWr_n    (iWr_n),
        .iData    (ioFifoData),
        .rdSync   (rdSync),
        .wrSync   (wrSync),
        .rdFall   (rdFall),
        .rdRise   (rdRise),
        .wrFall   (wrFall),
        .dataSync (dataSync)
    );

    fifo_sync_8bit #(.pDepth(pHostRxDepth)) uHostToFpga (
        .clock(iClk), .reset(~iRst_n),
        .writeEnable(h2fPush), .writeData(iHostTxData),
        .readEnable(h2fPop), .readData(h2fHead),
        .full(h2fFull), .empty(h2fEmpty)
    );

    fifo_sync_8bit #(.pDepth(pHostTxDepth)) uFpgaToHost (
        .clock(iClk), .reset(~iRst_n),
        .writeEnable(f2hPush), .writeData(dataSync),
        .readEnable(f2hPop), .readData(oHostRxData),
        .full(f2hFull), .empty(f2hEmpty)
    );

    assign busCond      = !rdSync && !wrSync;
    assign oHostTxReady = hostReadyEn && !h2fFull;
    assign h2fPush      = iHostTxValid && oHostTxReady;
    assign oHostRxValid = !f2hEmpty;
    assign f2hPop       = oHostRxValid && iHostRxReady;

    // The bus comes up on the last delay cycle so that RD# fall to data is
    // exactly sync + pRdDataDly; it drops the moment both strobes are low.
    assign busDrive   = !busCond && ((rdState == R_DRIVE) ||
                        ((rdState == R_DLY) && (rdCnt == '0)));
    assign ioFifoData = busDrive ? h2fHead : 8'hzz;
    assign oRxF_n     = rxfReg;
    assign oTxE_n     = txeReg;

    // Read strobe FSM. A bus conflict overrides everything and parks the
    // FSM in precharge without consuming the head byte.
    always_comb begin
        rdStateNext = rdState;
        rdCntNext   = rdCnt;
        h2fPop      = 1'b0;
        rdErrSet    = 1'b0;
        busErrSet   = 1'b0;
        if (busCond) begin
            busErrSet   = 1'b1;
            rdStateNext = R_PRE;
            rdCntNext   = cntW'(pRxfPrechg - 1);
        end else begin
            if (rdFall && rxfReg) rdErrSet = 1'b1;
            case (rdState)
                R_IDLE: begin
                    if (rdFall && !rxfReg) begin
                        rdStateNext = R_DLY;
                        rdCntNext   = cntW'(pRdDataDly - 1);
                    end
                end
                R_DLY: begin
                    if (rdSync) begin
                        rdStateNext = R_PRE;
                        rdCntNext   = cntW'(pRxfPrechg - 1);
                    end else if (rdCnt == '0) begin
                        rdStateNext = R_DRIVE;
                    end else begin
                        rdCntNext = rdCnt - cntOne;
                    end
                end
                R_DRIVE: begin
                    if (rdRise) begin
                        h2fPop      = 1'b1;
                        rdStateNext = R_PRE;
                        rdCntNext   = cntW'(pRxfPrechg - 1);
                    end
                end
                R_PRE: begin
                    if (rdCnt == '0) rdStateNext = R_IDLE;
                    else             rdCntNext   = rdCnt - cntOne;
                end
                default: rdStateNext = R_IDLE;
            endcase
        end
    end

    // Write strobe FSM. Pushes the byte seen alongside the synced WR# fall,
    // then holds TXE# high through precharge and until WR# returns high.
    always_comb begin
        wrStateNext = wrState;
        wrCntNext   = wrCnt;
        f2hPush     = 1'b0;
        wrErrSet    = 1'b0;
        if (wrFall && !busCond && txeReg) wrErrSet = 1'b1;
        case (wrState)
            W_IDLE: begin
                if (wrFall && !busCond && !txeReg) begin
                    f2hPush     = 1'b1;
                    wrStateNext = W_PRE;
                    wrCntNext   = cntW'(pTxePrechg - 1);
                end
            end
            W_PRE: begin
                if (wrCnt == '0) wrStateNext = W_WAIT;
                else             wrCntNext   = wrCnt - cntOne;
            end
            W_WAIT: begin
                if (wrSync) wrStateNext = W_IDLE;
            end
            default: wrStateNext = W_IDLE;
        endcase
    end

    // State, counters, flags and sticky errors. The flags are registered
    // from the next state so they never lag the FSM they describe.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            rdState     <= R_IDLE;
            wrState     <= W_IDLE;
            rdCnt       <= '0;
            wrCnt       <= '0;
            rxfReg      <= 1'b1;
            txeReg      <= 1'b1;
            hostReadyEn <= 1'b0;
            oRdErr      <= 1'b0;
            oWrErr      <= 1'b0;
            oBusErr     <= 1'b0;
        end else begin
            rdState     <= rdStateNext;
            wrState     <= wrStateNext;
            rdCnt       <= rdCntNext;
            wrCnt       <= wrCntNext;
            rxfReg      <= !((rdStateNext == R_IDLE) && !h2fEmpty);
            txeReg      <= !((wrStateNext == W_IDLE) && !f2hFull);
            hostReadyEn <= 1'b1;
            oRdErr      <= rdErrSet  || (oRdErr  && !iErrClr);
            oWrErr      <= wrErrSet  || (oWrErr  && !iErrClr);
            oBusErr     <= busErrSet || (oBusErr && !iErrClr);
        end
    end

endmodule

// File: tb/tb_ft245_async_responder.sv
// tb_ft245_async_responder
// Self-checking bench: hand-timed sequences, a transaction table and a
// randomized mix checked against byte-queue models of both directions.
module tb_ft245_async_responder;

    localparam int RD_DLY = 2;
    localparam int RXF_PRE = 3;
    localparam int TXE_PRE = 3;
    localparam int DEPTH = 8;

    logic       clock;
    logic       iRst_n;
    logic       iHostTxValid;
    logic [7:0] iHostTxData;
    logic       oHostTxReady;
    logic       oHostRxValid;
    logic [7:0] oHostRxData;
    logic       iHostRxReady;
    logic       iRd_n;
    logic       iWr_n;
    logic       oRxF_n;
    logic       oTxE_n;
    logic       iErrClr;
    logic       oRdErr;
    logic       oWrErr;
    logic       oBusErr;
    logic       tbDrive;
    logic [7:0] tbData;
    wire  [7:0] fifoBus;

    int testsRun = 0;
    int testsFailed = 0;

    logic [7:0] h2fQ[$];
    logic [7:0] f2hQ[$];

    typedef enum logic [1:0] {OP_HPUSH, OP_MREAD, OP_MWRITE, OP_HPOP} op_t;
    typedef struct {
        op_t        op;
        logic [7:0] stimByte;
        logic [7:0] expByte;
    } vec_t;
    vec_t vecs [10];

    // The released bus floats high so "not driven" reads as 0xFF.
    for (genvar g = 0; g < 8; g++) begin : gPull
        pullup (fifoBus[g]);
    end
    assign fifoBus = tbDrive ? tbData : 8'hzz;

    ft245_async_responder #(
        .pHostRxDepth(DEPTH), .pHostTxDepth(DEPTH), .pRdDataDly(RD_DLY),
        .pRxfPrechg(RXF_PRE), .pTxePrechg(TXE_PRE)
    ) dut (
        .iClk(clock), .iRst_n(iRst_n),
        .iHostTxValid(iHostTxValid), .iHostTxData(iHostTxData),
        .oHostTxReady(oHostTxReady), .oHostRxValid(oHostRxValid),
        .oHostRxData(oHostRxData), .iHostRxReady(iHostRxReady),
        .ioFifoData(fifoBus), .iRd_n(iRd_n), .iWr_n(iWr_n),
        .oRxF_n(oRxF_n), .oTxE_n(oTxE_n), .iErrClr(iErrClr),
        .oRdErr(oRdErr), .oWrErr(oWrErr), .oBusErr(oBusErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {7'b0, actual}, {7'b0, expected});
    endtask

    task automatic hostPush(input logic [7:0] value);
        iHostTxValid = 1'b1;
        iHostTxData  = value;
        tick();
        iHostTxValid = 1'b0;
    endtask

    task automatic hostPop(input string name, input logic [7:0] expected);
        for (int n = 0; n < 50 && !oHostRxValid; n++) tick();
        checkBit({name, "-valid"}, oHostRxValid, 1'b1);
        checkOutput(name, oHostRxData, expected);
        iHostRxReady = 1'b1;
        tick();
        iHostRxReady = 1'b0;
    endtask

    task automatic masterRead(input string name, input logic [7:0] expected);
        logic [7:0] got;
        for (int n = 0; n < 50 && oRxF_n; n++) tick();
        checkBit({name, "-rxf"}, oRxF_n, 1'b0);
        iRd_n = 1'b0;
        repeat (RD_DLY + 3) tick();
        got = fifoBus;
        iRd_n = 1'b1;
        checkOutput(name, got, expected);
        repeat (4) tick();
        checkOutput({name, "-release"}, fifoBus, 8'hFF);
    endtask

    task automatic masterWrite(input string name, input logic [7:0] value);
        for (int n = 0; n < 50 && oTxE_n; n++) tick();
        checkBit({name, "-txe"}, oTxE_n, 1'b0);
        tbData  = value;
        tbDrive = 1'b1;
        iWr_n   = 1'b0;
        repeat (6) tick();
        iWr_n = 1'b1;
        repeat (3) tick();
        tbDrive = 1'b0;
    endtask

    task automatic clearErrors();
        iErrClr = 1'b1;
        tick();
        iErrClr = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string name;
        name = $sformatf("vec%0d", idx);
        case (v.op)
            OP_HPUSH: begin
                checkBit({name, "-ready"}, oHostTxReady, 1'b1);
                hostPush(v.stimByte);
            end
            OP_MREAD:  masterRead(name, v.expByte);
            OP_MWRITE: masterWrite(name, v.stimByte);
            default:   hostPop(name, v.expByte);
        endcase
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] b;
        iRst_n = 1'b0; iHostTxValid = 1'b0; iHostTxData = '0; iHostRxReady = 1'b0;
        iRd_n = 1'b1; iWr_n = 1'b1; iErrClr = 1'b0; tbDrive = 1'b0; tbData = '0;

        // Reset state
        repeat (3) tick();
        checkBit("rstRxf", oRxF_n, 1'b1);
        checkBit("rstTxe", oTxE_n, 1'b1);
        checkBit("rstTxReady", oHostTxReady, 1'b0);
        checkBit("rstRxValid", oHostRxValid, 1'b0);
        checkOutput("rstErrs", {5'b0, oRdErr, oWrErr, oBusErr}, 8'h00);
        checkOutput("rstBus", fifoBus, 8'hFF);
        iRst_n = 1'b1;
        tick();
        checkBit("relTxReady", oHostTxReady, 1'b1);
        tick();
        checkBit("relTxe", oTxE_n, 1'b0);
        checkBit("relRxf", oRxF_n, 1'b1);

        // Host push to RXF#, RD# fall to drive, RD# rise to release
        hostPush(8'hA5);
        checkBit("rxfPush1", oRxF_n, 1'b1);
        tick();
        checkBit("rxfPush2", oRxF_n, 1'b0);
        iRd_n = 1'b0;
        repeat (3) tick();
        checkOutput("busBeforeDrive", fifoBus, 8'hFF);
        tick();
        checkOutput("busDriven", fifoBus, 8'hA5);
        checkBit("rxfDuringRead", oRxF_n, 1'b1);
        iRd_n = 1'b1;
        repeat (2) tick();
        checkOutput("busHeld", fifoBus, 8'hA5);
        tick();
        checkOutput("busReleased", fifoBus, 8'hFF);
        repeat (6) tick();
        checkBit("rxfEmpty", oRxF_n, 1'b1);

        // RXF# precharge with a byte still queued
        hostPush(8'h11);
        hostPush(8'h22);
        repeat (2) tick();
        iRd_n = 1'b0;
        repeat (4) tick();
        checkOutput("preRead", fifoBus, 8'h11);
        iRd_n = 1'b1;
        repeat (5) tick();
        checkBit("rxfPrechg", oRxF_n, 1'b1);
        tick();
        checkBit("rxfAfterPrechg", oRxF_n, 1'b0);
        masterRead("preRead2", 8'h22);

        // WR# fall to push and TXE# precharge
        tbData = 8'h3C; tbDrive = 1'b1; iWr_n = 1'b0;
        repeat (2) tick();
        checkBit("txeBeforePush", oTxE_n, 1'b0);
        checkBit("validBeforePush", oHostRxValid, 1'b0);
        tick();
        checkBit("txeAfterPush", oTxE_n, 1'b1);
        checkBit("validAfterPush", oHostRxValid, 1'b1);
        repeat (2) tick();
        checkBit("txePrechg", oTxE_n, 1'b1);
        iWr_n = 1'b1;
        repeat (3) tick();
        tbDrive = 1'b0;
        masterWrite("wrC3", 8'hC3);
        hostPop("pop3C", 8'h3C);
        hostPop("popC3", 8'hC3);

        // Transaction table
        vecs[0] = '{OP_HPUSH,  8'h10, 8'h00};
        vecs[1] = '{OP_HPUSH,  8'h20, 8'h00};
        vecs[2] = '{OP_MREAD,  8'h00, 8'h10};
        vecs[3] = '{OP_MWRITE, 8'h99, 8'h00};
        vecs[4] = '{OP_MREAD,  8'h00, 8'h20};
        vecs[5] = '{OP_HPOP,   8'h00, 8'h99};
        vecs[6] = '{OP_MWRITE, 8'h01, 8'h00};
        vecs[7] = '{OP_MWRITE, 8'h80, 8'h00};
        vecs[8] = '{OP_HPOP,   8'h00, 8'h01};
        vecs[9] = '{OP_HPOP,   8'h00, 8'h80};
        for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

        // Host->FPGA fill, drain and refill across pointer wrap
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < DEPTH; i++) begin
                b = 8'($urandom);
                checkBit("wrapReadyBefore", oHostTxReady, 1'b1);
                hostPush(b);
                h2fQ.push_back(b);
                checkBit("wrapReadyAfter", oHostTxReady, h2fQ.size() < DEPTH);
            end
            while (h2fQ.size() != 0) masterRead("wrapRead", h2fQ.pop_front());
        end

        // FPGA->host full: TXE# held, extra write flagged, nothing lost
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            masterWrite("fullWrite", b);
            f2hQ.push_back(b);
        end
        repeat (10) tick();
        checkBit("txeHeldFull", oTxE_n, 1'b1);
        tbData = 8'hEE; tbDrive = 1'b1; iWr_n = 1'b0;
        repeat (5) tick();
        checkBit("wrErrSet", oWrErr, 1'b1);
        iWr_n = 1'b1;
        repeat (3) tick();
        tbDrive = 1'b0;
        hostPop("fullPop", f2hQ.pop_front());
        for (int n = 0; n < 20 && oTxE_n; n++) tick();
        checkBit("txeAfterPop", oTxE_n, 1'b0);
        while (f2hQ.size() != 0) hostPop("fullDrain", f2hQ.pop_front());
        repeat (2) tick();
        checkBit("noExtraByte", oHostRxValid, 1'b0);
        clearErrors();
        checkBit("wrErrClr", oWrErr, 1'b0);

        // RD# on empty buffer
        iRd_n = 1'b0;
        repeat (5) tick();
        checkBit("rdErrSet", oRdErr, 1'b1);
        checkOutput("rdErrBus", fifoBus, 8'hFF);
        iRd_n = 1'b1;
        repeat (4) tick();
        clearErrors();
        checkBit("rdErrClr", oRdErr, 1'b0);

        // Both strobes low during a read: release, no pop, no push
        hostPush(8'h77);
        repeat (2) tick();
        iRd_n = 1'b0;
        repeat (5) tick();
        checkOutput("busErrDrive", fifoBus, 8'h77);
        iWr_n = 1'b0;
        repeat (3) tick();
        checkOutput("busErrRelease", fifoBus, 8'hFF);
        checkBit("busErrSet", oBusErr, 1'b1);
        iRd_n = 1'b1; iWr_n = 1'b1;
        repeat (10) tick();
        checkBit("busErrNoPush", oHostRxValid, 1'b0);
        masterRead("busErrKeep", 8'h77);
        clearErrors();
        checkBit("busErrClr", oBusErr, 1'b0);

        // Randomized mix against the queue models
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: if (h2fQ.size() < DEPTH) begin
                       b = 8'($urandom);
                       hostPush(b);
                       h2fQ.push_back(b);
                   end
                1: if (h2fQ.size() != 0) masterRead("rndRead", h2fQ.pop_front());
                2: if (f2hQ.size() < DEPTH) begin
                       b = 8'($urandom);
                       masterWrite("rndWrite", b);
                       f2hQ.push_back(b);
                   end
                default: if (f2hQ.size() != 0) hostPop("rndPop", f2hQ.pop_front());
            endcase
            checkBit("rndTxReady", oHostTxReady, h2fQ.size() < DEPTH);
            checkBit("rndRxValid", oHostRxValid, f2hQ.size() != 0);
        end
        checkOutput("rndErrs", {5'b0, oRdErr, oWrErr, oBusErr}, 8'h00);
        while (h2fQ.size() != 0) masterRead("rndDrainRd", h2fQ.pop_front());
        while (f2hQ.size() != 0) hostPop("rndDrainPop", f2hQ.pop_front());

        // Reset asserted while the bus is driven
        hostPush(8'h42);
        repeat (2) tick();
        iRd_n = 1'b0;
        repeat (5) tick();
        checkOutput("rstMidDrive", fifoBus, 8'h42);
        iRst_n = 1'b0;
        #1;
        checkOutput("rstMidRelease", fifoBus, 8'hFF);
        checkBit("rstMidRxf", oRxF_n, 1'b1);
        iRd_n = 1'b1;
        repeat (2) tick();
        iRst_n = 1'b1;
        repeat (6) tick();
        checkBit("rstMidCleared", oRxF_n, 1'b1);
        checkBit("rstMidReady", oHostTxReady, 1'b1);
        checkOutput("rstMidErrs", {5'b0, oRdErr, oWrErr, oBusErr}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ft245_async_responder.md
# ft245_async_responder

Synthesizable device-side model of the FT2232H asynchronous 245-FIFO pin interface: the chip end of the bus the FPGA FTDI master drives. It asserts RXF#/TXE#, answers RD# strobes by driving the data bus, and latches bytes on WR# strobes, with host-side byte streams standing in for USB. It is used for on-board loopback and for closed-loop simulation of the FTDI master without a physical chip.

## Interface
- pHostRxDepth, 8: bytes buffered host→FPGA (power of 2, ≥2)
- pHostTxDepth, 8: bytes buffered FPGA→host (power of 2, ≥2)
- pRdDataDly, 2: iClk cycles from synced RD# fall to data driven (≥1)
- pRxfPrechg, 3: cycles RXF# held high after RD# rise (≥1)
- pTxePrechg, 3: cycles TXE# held high after a write is latched (≥1)
- iClk  in  1  system clock, ≥4× strobe rate
- iRst_n  in  1  asynchronous, active-low reset
- iHostTxValid  in  1  host byte available to send toward FPGA
- iHostTxData  in  8  host byte
- oHostTxReady  out  1  host→FPGA buffer not full
- oHostRxValid  out  1  FPGA→host byte available
- oHostRxData  out  8  FPGA→host byte
- iHostRxReady  in  1  host consumes byte
- ioFifoData  inout  8  FTDI data bus
- iRd_n  in  1  RD# from master (asynchronous)
- iWr_n  in  1  WR# from master (asynchronous)
- oRxF_n  out  1  RXF#, low = byte readable
- oTxE_n  out  1  TXE#, low = byte writable
- iErrClr  in  1  clears sticky errors
- oRdErr  out  1  sticky: RD# fell while RXF# high
- oWrErr  out  1  sticky: WR# fell while TXE# high
- oBusErr  out  1  sticky: RD# and WR# both low

## Operation
- iRd_n, iWr_n, ioFifoData each pass a 2-flop synchronizer; edges detected on synced signals only; data sampled from the same synced stage as WR#.
- Host side: push when iHostTxValid & oHostTxReady; pop when oHostRxValid & iHostRxReady (first-word-fall-through).
- Read FSM: R_IDLE → (RD# fall, RXF# low) R_DLY, count pRdDataDly → R_DRIVE: bus driven with FIFO head → (RD# rise) pop, release bus, R_PRE for pRxfPrechg → R_IDLE. oRxF_n = 1 in every state except R_IDLE with buffer non-empty.
- Write FSM: W_IDLE → (WR# fall, TXE# low) push synced data, W_PRE for pTxePrechg → W_WAIT until synced WR# high → W_IDLE. oTxE_n = 1 except in W_IDLE with buffer not full.
- RD# fall with RXF# high: set oRdErr, stay R_IDLE, bus not driven. WR# fall with TXE# high: set oWrErr, no push.
- Both synced strobes low: set oBusErr, release bus immediately, read FSM → R_PRE without popping.
- iErrClr clears errors; a same-cycle new error wins (stays set).

## Timing
- Reset: oRxF_n=1, oTxE_n=1, bus tristated, oHostTxReady=0 during reset then 1 the cycle after release, oHostRxValid=0, all errors 0, FSMs idle, buffers empty.
- Reset mid-transfer: bus released asynchronously; partial read not popped.
- Host push to oRxF_n low: 2 cycles (FIFO update + flag register), in R_IDLE only.
- RD# pin fall to bus driven: 2 sync + pRdDataDly cycles. RD# rise to bus released: 2 sync + 1.
- WR# pin fall to push: 3 cycles; oTxE_n high the cycle after push.
- Buffer full: oTxE_n stays high after W_PRE until a host pop; last-slot push makes it high with no gap.
- Pointer wrap: FIFOs carry depth+1-bit pointers; full/empty correct across wrap.

## Structure
- Package ft245_pkg: read/write state enums, default delay constants, counter width = $clog2(max delay)+1.
- Sub-module ft245_pin_sync: 2-flop synchronizer + edge detect for RD#, WR#, bus.
- Both buffers reuse existing fifo_sync_8bit, reset driven from ~iRst_n.

## Test plan
- Host pushes 0xA5 → oRxF_n low 2 cycles later; master RD# pulse reads 0xA5 on bus, RXF# high pRxfPrechg cycles, then high (empty).
- Master writes 0x3C, 0xC3 → oHostRxData 0x3C then 0xC3; oTxE_n high ≥pTxePrechg after each.
- Fill host→FPGA with 8 bytes, read all 8, push 8 more → 16 bytes in order across wrap, oHostTxReady low only when 8 stored.
- Write 8 bytes with iHostRxReady=0 → oTxE_n stays high; 9th WR# sets oWrErr, no data lost; one host pop → TXE# low.
- RD# on empty → oRdErr=1, bus stays Z; iErrClr → 0. RD# and WR# low together → oBusErr=1, bus released.
- Assert iRst_n low during R_DRIVE → bus Z same cycle, byte still readable after reset? No: buffers cleared, oRxF_n=1.
